input_trigger_ctrl: RTL
=======================

Name: input_trigger_ctrl

Overview:
- Sequences the FPGA input channels toward the AVR.
- Synchronises and debounces N_CH raw input lines, and latches a pending event on each filtered rising edge.
- Grants pending channels round-robin and presents each one to the AVR as a single trigger/acknowledge transaction carrying the channel number.
- Sits between the Input_Signal front-end lines and the FPGA2AVR trigger interface.

Parameters:
- N_CH, 4, number of input channels (2..8).
- DEBOUNCE, 16, consecutive stable cycles needed to change a filtered level (>=2).
- ACK_TIMEOUT, 1024, cycles to wait for Avr_Ack before abandoning a transaction.
- ID_W, 2, width of Ch_Id; must equal clog2(N_CH).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- In_Sig  in  N_CH  raw asynchronous input lines.
- Enable  in  1  when high, new grants are allowed.
- Err_Clr  in  1  synchronous pulse that clears Timeout_Err.
- Avr_Ack  in  1  AVR acknowledge level (synchronised internally, 2 FF).
- Trig_Out  out  1  trigger to AVR; held high for the whole request phase.
- Ch_Id  out  ID_W  granted channel; stable while Trig_Out is high.
- Busy  out  1  high in any state other than IDLE.
- Pending  out  N_CH  latched, not-yet-granted events.
- Timeout_Err  out  1  sticky flag: an ack timeout occurred.

Behaviour:
- Reset (Reset=0, async):
  - All outputs go to 0.
  - Filtered levels and sync FFs go to 0; debounce counters go to 0.
  - FSM goes to IDLE; round-robin pointer goes to N_CH-1, so channel 0 has first priority.
- Synchroniser: 2-FF chain per In_Sig bit and for Avr_Ack.
- Debounce, per channel:
  - Counter resets to 0 whenever the synced bit equals the filtered bit.
  - Otherwise it increments. When it reaches DEBOUNCE-1, the filtered bit takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE cycles never change the filtered bit.
- Edge latch:
  - A filtered 0->1 sets Pending[i] on the next edge.
  - Falling edges are ignored.
  - If a set and a grant-clear hit the same channel in the same cycle, the set wins and Pending stays 1.
  - A repeated edge on an already pending channel is merged; there is no counting.
- Arbiter:
  - Round-robin search starting at pointer+1, wrapping modulo N_CH.
  - On a grant, the pointer takes the granted index.
- FSM (registered outputs):
  - IDLE: if Enable=1 and Pending!=0, pick channel g, clear Pending[g], load Ch_Id=g, set Trig_Out=1 and Busy=1, go to REQ. The transition takes 1 cycle.
  - REQ:
    - Timeout counter increments each cycle.
    - If synced Avr_Ack=1: Trig_Out=0, go to REL.
    - Else, if the counter reaches ACK_TIMEOUT-1: Trig_Out=0, set Timeout_Err=1, go to IDLE. The event is dropped, not re-queued.
  - REL: wait for synced Avr_Ack=0, then go to IDLE with Busy=0. REL has no timeout.
  - Ch_Id holds its last value in IDLE.
- Latency: with the controller idle and no other pending channel, In_Sig rising and staying stable gives Trig_Out=1 exactly DEBOUNCE+4 edges after the first edge that samples In_Sig high. This is 2 sync edges, DEBOUNCE to filter, 1 to latch Pending, and 1 to grant.
- Back-to-back transactions: the earliest next Trig_Out is 1 cycle after returning to IDLE. Trig_Out is therefore low for at least 1 cycle between transactions.
- Enable=0:
  - An in-progress transaction completes normally.
  - Pending keeps collecting events; no new grant is made until Enable=1.
- Err_Clr: clears Timeout_Err on the next edge. A timeout in the same cycle wins, and the flag stays 1.
- Avr_Ack already high while in IDLE: no effect. After the next grant, REQ sees ack immediately and exits on the following cycle.
- Reset mid-transaction: Trig_Out drops asynchronously and all pending events are lost.

Test Plan:
- Reset release, In_Sig=0001 stable from cycle 10, Avr_Ack echoes Trig_Out after 3 cycles -> Trig_Out rises at cycle 10+DEBOUNCE+4 (=30) with Ch_Id=0. One transaction only; Busy falls after Avr_Ack returns low.
- 5-cycle pulse on In_Sig[2] (DEBOUNCE=16) -> Pending stays 0000; Trig_Out never asserts.
- In_Sig 0000->1011 simultaneously, AVR acks each -> grants in order Ch_Id 0, 1, 3; Pending goes 1011 -> 1010 -> 1000 -> 0000; Trig_Out low ≥1 cycle between grants.
- Grant ch1, hold Avr_Ack=0 -> Trig_Out falls after ACK_TIMEOUT cycles; Timeout_Err=1 and stays 1 until an Err_Clr pulse, then 0. FSM back in IDLE.
- Enable=0, edges on ch0 and ch3 -> Pending=1001 and Trig_Out=0. Enable=1 -> ch0 granted next cycle, then ch3.
- Reset asserted while in REQ with Pending=0100 -> Trig_Out, Busy and Pending go to 0 immediately; after release, the first grant is channel 0.

Source files
------------

// File: rtl/input_trigger_ctrl.sv
// input_trigger_ctrl: synchronises and debounces input lines, latches rising
// edges as pending events and hands them to the AVR one at a time through a
// round-robin trigger/acknowledge handshake.
module input_trigger_ctrl #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned DEBOUNCE    = 16,
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter int unsigned ID_W        = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [N_CH-1:0] In_Sig,
   input  logic            Enable,
   input  logic            Err_Clr,
   input  logic            Avr_Ack,
   output logic            Trig_Out,
   output logic [ID_W-1:0] Ch_Id,
   output logic            Busy,
   output logic [N_CH-1:0] Pending,
   output logic            Timeout_Err
);

   localparam int unsigned DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   state_t            state;
   logic [N_CH-1:0]   in_s1;
   logic [N_CH-1:0]   in_s2;
   logic              ack_s1;
   logic              ack_s2;
   logic [N_CH-1:0]   filt;
   logic [N_CH-1:0]   filt_d;
   logic [DB_W-1:0]   db_cnt [N_CH];
   logic [ID_W-1:0]   rr_ptr;
   logic [TO_W-1:0]   to_cnt;

   logic [N_CH-1:0]   rise_c;
   logic              gnt_hit_c;
   logic [ID_W-1:0]   gnt_idx_c;
   logic              gnt_fire_c;
   logic [N_CH-1:0]   gnt_mask_c;
   int unsigned       arb_idx;

   // Two-flop synchronisers for the raw inputs and the AVR acknowledge
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         in_s1  <= '0;
         in_s2  <= '0;
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         in_s1  <= In_Sig;
         in_s2  <= in_s1;
         ack_s1 <= Avr_Ack;
         ack_s2 <= ack_s1;
      end
   end

   // Per-channel debounce: filtered level follows only after DEBOUNCE stable samples
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         filt   <= '0;
         filt_d <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         filt_d <= filt;
         for (int i = 0; i < int'(N_CH); i++) begin
            if (in_s2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
               filt[i]   <= in_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Rising-edge detect on the filtered levels
   assign rise_c = filt & ~filt_d;

   // Round-robin search starting one past the last granted channel
   always_comb begin
      gnt_hit_c = 1'b0;
      gnt_idx_c = '0;
      arb_idx   = 0;
      for (int unsigned k = N_CH; k >= 1; k--) begin
         arb_idx = (32'(rr_ptr) + k) % N_CH;
         if (Pending[ID_W'(arb_idx)]) begin
            gnt_hit_c = 1'b1;
            gnt_idx_c = ID_W'(arb_idx);
         end
      end
   end

   assign gnt_fire_c = (state == IDLE) && Enable && gnt_hit_c;
   assign gnt_mask_c = gnt_fire_c ? (N_CH'(1) << gnt_idx_c) : '0;

   // Pending event latch; a new edge wins over a same-cycle grant clear
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Pending <= '0;
      end else begin
         Pending <= (Pending & ~gnt_mask_c) | rise_c;
      end
   end

   // Handshake FSM with registered outputs
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         Trig_Out    <= 1'b0;
         Ch_Id       <= '0;
         Busy        <= 1'b0;
         Timeout_Err <= 1'b0;
         rr_ptr      <= ID_W'(N_CH - 1);
         to_cnt      <= '0;
      end else begin
         // A timeout later in this block overrides the clear
         if (Err_Clr) begin
            Timeout_Err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (gnt_fire_c) begin
                  Ch_Id    <= gnt_idx_c;
                  rr_ptr   <= gnt_idx_c;
                  Trig_Out <= 1'b1;
                  Busy     <= 1'b1;
                  to_cnt   <= '0;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (ack_s2) begin
                  Trig_Out <= 1'b0;
                  state    <= REL;
               end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                  Trig_Out    <= 1'b0;
                  Busy        <= 1'b0;
                  Timeout_Err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            REL: begin
               if (!ack_s2) begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               Trig_Out <= 1'b0;
               Busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
